alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Registered, handshaked successor to the combinational ALU wrapper; parametrised data width.
- Single-cycle ops complete in one registered stage; multiplication runs on an iterative shift-add unit.
- valid/ready on input and output, so the block drops into a streaming datapath or a CPU execute stage.
- Produces zero/carry/overflow/illegal flags alongside the result.

Parameters:
- DATA_WIDTH, 32, operand and result width; legal values are 8..64, even.
- MUL_EN, 1, when 0 the MUL ops are illegal and no multiplier is instantiated.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted on a cycle with in_valid & in_ready.
- op  in  4  alu_op_t opcode.
- a  in  DATA_WIDTH  operand 1.
- b  in  DATA_WIDTH  operand 2.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes the result on a cycle with out_valid & out_ready.
- r  out  DATA_WIDTH  result.
- flags  out  4  {illegal, ovf, carry, zero}.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MULLO, 11 MULHI (unsigned).
- Opcodes 12..15 are illegal. MULLO and MULHI are also illegal when MUL_EN=0.
- An illegal op completes in 1 cycle with r=0 and illegal=1.
- Shift amount is b[$clog2(DATA_WIDTH)-1:0]. SLT and SLTU return 0 or 1, zero-extended.
- carry:
  - ADD: carry-out.
  - SUB: borrow, i.e. a<b unsigned.
  - All other ops: 0.
- ovf: signed overflow for ADD and SUB; 0 otherwise.
- zero: r==0 for every op, including illegal ones.
- FSM states:
  - IDLE: no result held.
  - BUSY: multiply in progress.
  - HOLD: result held.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is 0 in BUSY.
- Accepting a single-cycle op: r and flags are registered at that edge, state goes to HOLD, out_valid=1 from the next cycle.
  - Latency is 1.
  - With out_ready held high, throughput is 1 op per cycle. The output is released and replaced on the same edge.
- Accepting MULLO or MULHI: state goes to BUSY and a counter is loaded with DATA_WIDTH.
  - One partial product is accumulated per cycle into a 2*DATA_WIDTH register.
  - When the counter reaches 0, state goes to HOLD.
  - out_valid rises exactly DATA_WIDTH+1 cycles after the accept edge.
- HOLD & !out_ready: r, flags and out_valid are frozen. No new op is accepted.
- HOLD & out_ready & !in_valid: state goes to IDLE and out_valid drops at the next edge.
- Operands are captured at the accept edge. Changes on a/b/op afterwards have no effect.
- Reset values: out_valid=0, r=0, flags=0, state=IDLE. in_ready is 1 one cycle after reset deasserts.
- Reset asserted mid-multiply aborts it immediately, asynchronously. No result is ever emitted for the aborted op.
- Width rules: ADD/SUB are computed at DATA_WIDTH+1 bits for carry. MUL is unsigned DATA_WIDTH x DATA_WIDTH giving 2*DATA_WIDTH bits; MULLO returns the low half, MULHI the high half.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t, a 4-bit enum with the codes above.
  - alu_flags_t, a packed struct {illegal, ovf, carry, zero}.
  - state enum alu_state_t {IDLE, BUSY, HOLD}.
  - function is_mul(alu_op_t).
- Sub-module alu_mul_seq is the iterative shift-add multiplier.
  - Interface: start, a, b, busy, done, p[2*DATA_WIDTH-1:0].
  - Generated only when MUL_EN=1.
- Combinational single-cycle datapath lives in the top module.
- The walu_if interface is extended with handshake signals for the bench.

Test Plan:
- Back-to-back throughput: ADD a=32'hFFFF_FFFF, b=1 then SUB a=0, b=1, out_ready=1.
  - Cycle 1: r=0, carry=1, zero=1, ovf=0.
  - Cycle 2: r=32'hFFFF_FFFF, carry=1, ovf=0.
  - in_ready is never low.
- Signed overflow: ADD a=32'h7FFF_FFFF, b=1 -> r=32'h8000_0000, ovf=1, carry=0.
- Shift masking: SRA a=32'h8000_0000, b=33 -> shift amount is 1, r=32'hC000_0000.
- Multiply: MULHI a=b=32'hFFFF_FFFF -> out_valid exactly 33 cycles after accept, r=32'hFFFF_FFFE, in_ready=0 throughout BUSY.
  - A follow-up MULLO with the same operands gives r=1.
- Backpressure: out_ready=0 for 5 cycles after XOR a=32'hF0F0_F0F0, b=32'hFFFF_FFFF.
  - r stays 32'h0F0F_0F0F and in_ready stays 0.
  - When out_ready rises, the pending input is accepted on that same edge.
- Illegal op and reset abort:
  - op=14 -> r=0, flags=4'b1001.
  - Assert rst_n=0 at cycle 10 of a MULLO -> out_valid=0 immediately and no result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, flag bundle, control states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MULLO = 4'd10,
        OP_MULHI = 4'd11
    } alu_op_t;

    // Bit order matches the flags output: {illegal, ovf, carry, zero}.
    typedef struct packed {
        logic illegal;
        logic ovf;
        logic carry;
        logic zero;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } alu_state_t;

    function automatic logic is_mul(alu_op_t op);
        return (op == OP_MULLO) || (op == OP_MULHI);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: DATA_WIDTH cycles of accumulation after start, then done is high.
// Backpressure: none; caller only pulses start while busy is low.
module alu_mul_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] p
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [CW-1:0]           cnt_q;
    logic                    busy_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0]   mplier_q;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            cnt_q    <= CW'(DATA_WIDTH);
            busy_q   <= 1'b1;
            acc_q    <= '0;
            mcand_q  <= {{DATA_WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
            end else begin
                // The consumer samples p on this edge; drop busy behind it.
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);
    assign p    = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered valid/ready ALU with flags; multiply via iterative shift-add unit.
// Latency: 1 cycle for single-cycle/illegal ops, DATA_WIDTH+1 cycles for MULLO/MULHI.
// Backpressure: result held while out_ready is low; in_ready drops while busy or holding a blocked result.
module alu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter bit MUL_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] r,
    output logic [3:0]            flags
);

    import alu_pkg::*;

    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    alu_state_t            state_q, state_d;
    alu_op_t               op_e;
    logic                  op_mul;
    logic                  accept;
    logic                  mul_start;
    logic                  mul_busy, mul_done, mul_fin;
    logic [2*W-1:0]        mul_p;
    logic                  mul_hi_q;
    logic [W-1:0]          mul_res;
    alu_flags_t            mul_fl;
    logic [SHW-1:0]        shamt;
    logic [W:0]            sum, diff;
    logic [W-1:0]          alu_res;
    alu_flags_t            alu_fl;
    logic [W-1:0]          r_q;
    alu_flags_t            flags_q;

    assign op_e   = alu_op_t'(op);
    assign op_mul = (MUL_EN != 1'b0) && is_mul(op_e);
    assign shamt  = b[SHW-1:0];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};

    // Single-cycle datapath; anything not handled here (including MUL ops) reports illegal.
    always_comb begin
        alu_res = '0;
        alu_fl  = '0;
        case (op_e)
            OP_ADD: begin
                alu_res      = sum[W-1:0];
                alu_fl.carry = sum[W];
                alu_fl.ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_res      = diff[W-1:0];
                alu_fl.carry = diff[W];
                alu_fl.ovf   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
            default: alu_fl.illegal = 1'b1;
        endcase
        alu_fl.zero = (alu_res == '0);
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_seq #(
                .DATA_WIDTH (W)
            ) u_mul (
                .clk   (clk),
                .rst_n (rst_n),
                .start (mul_start),
                .a     (a),
                .b     (b),
                .busy  (mul_busy),
                .done  (mul_done),
                .p     (mul_p)
            );
        end else begin : g_no_mul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_p    = '0;
        end
    endgenerate

    assign mul_fin = mul_busy && mul_done;

    // Select the requested half of the product and derive its flags.
    always_comb begin
        mul_res     = mul_hi_q ? mul_p[2*W-1:W] : mul_p[W-1:0];
        mul_fl      = '0;
        mul_fl.zero = (mul_res == '0);
    end

    // Handshake and next-state logic; a held result may be replaced on the edge it is consumed.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        accept    = in_valid && in_ready;
        mul_start = accept && op_mul;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = op_mul ? BUSY : HOLD;
                end
            end
            BUSY: begin
                if (mul_fin) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = accept ? (op_mul ? BUSY : HOLD) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register: loaded at accept for single-cycle ops, at multiply completion otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            flags_q  <= '0;
            mul_hi_q <= 1'b0;
        end else if (accept && !op_mul) begin
            r_q     <= alu_res;
            flags_q <= alu_fl;
        end else if (accept) begin
            mul_hi_q <= (op_e == OP_MULHI);
        end else if ((state_q == BUSY) && mul_fin) begin
            r_q     <= mul_res;
            flags_q <= mul_fl;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign r         = r_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: handshake, flags, shift masking, multiply latency, backpressure, reset abort.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_alu_pipe;

    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic [3:0]   flags;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(
        .DATA_WIDTH (W),
        .MUL_EN     (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an op, wait (bounded) for in_ready, complete the handshake, return 1 time unit after the accept edge.
    task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] er, input logic [3:0] ef);
        issue(tag, o, x, y);
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_r"}, 64'(r), 64'(er));
        check({tag, "_flags"}, 64'(flags), 64'(ef));
        tick();
    endtask

    // Leaves the result held so a follow-up op can be accepted straight from HOLD.
    task automatic run_mul(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] er);
        int lat;
        int rdy_hi;
        lat = 0;
        rdy_hi = 0;
        issue(tag, o, x, y);
        a = '0;
        b = '0;
        op = 4'd15;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_hi++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_busy_rdy"}, 64'(rdy_hi), 64'd0);
        check({tag, "_r"}, 64'(r), 64'(er));
        check({tag, "_flags"}, 64'(flags), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        a         = '0;
        b         = '0;

        // Reset state
        repeat (3) tick();
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_r", 64'(r), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back ADD then SUB with out_ready high
        out_ready = 1'b1;
        op = OP_ADD; a = 32'hFFFF_FFFF; b = 32'd1; in_valid = 1'b1;
        #1;
        check("b2b_rdy0", 64'(in_ready), 64'd1);
        tick();
        op = OP_SUB; a = 32'd0; b = 32'd1;
        #1;
        check("b2b_add_vld", 64'(out_valid), 64'd1);
        check("b2b_add_r", 64'(r), 64'd0);
        check("b2b_add_flags", 64'(flags), 64'b0011);
        check("b2b_rdy1", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("b2b_sub_vld", 64'(out_valid), 64'd1);
        check("b2b_sub_r", 64'(r), 64'hFFFF_FFFF);
        check("b2b_sub_flags", 64'(flags), 64'b0010);
        check("b2b_rdy2", 64'(in_ready), 64'd1);
        tick();
        check("b2b_drain_vld", 64'(out_valid), 64'd0);

        // Single-cycle directed vectors
        run_single("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b0100);
        run_single("sub_ovf",  OP_SUB,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0100);
        run_single("sub_zero", OP_SUB,  32'd5,         32'd5,         32'd0,         4'b0001);
        run_single("sra_mask", OP_SRA,  32'h8000_0000, 32'd33,        32'hC000_0000, 4'b0000);
        run_single("sll",      OP_SLL,  32'd1,         32'd31,        32'h8000_0000, 4'b0000);
        run_single("srl",      OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 4'b0000);
        run_single("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0000);
        run_single("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000);
        run_single("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0001);
        run_single("illegal14", 4'd14,  32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         4'b1001);
        run_single("illegal12", 4'd12,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         4'b1001);

        // Multiply: MULHI then MULLO accepted straight out of HOLD
        run_mul("mulhi", OP_MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mul("mullo", OP_MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("mul_drain_vld", 64'(out_valid), 64'd0);

        // Backpressure: held XOR result, pending ADD accepted on the release edge
        out_ready = 1'b0;
        issue("bp", OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
        op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_vld", 64'(out_valid), 64'd1);
            check("bp_hold_r", 64'(r), 64'h0F0F_0F0F);
            check("bp_hold_rdy", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_rise", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_vld", 64'(out_valid), 64'd1);
        check("bp_next_r", 64'(r), 64'd3);
        check("bp_next_flags", 64'(flags), 64'd0);
        tick();
        check("bp_drain_vld", 64'(out_valid), 64'd0);

        // Reset asserted mid-multiply
        issue("abort", OP_MULLO, 32'd3, 32'd5);
        repeat (10) tick();
        check("abort_busy_vld", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_rst_vld", 64'(out_valid), 64'd0);
        check("abort_rst_r", 64'(r), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        run_single("post_abort_or", OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
